// File: rtl/alu64_registered_if.sv
// Operand/result bundle for the registered 64-bit ALU.
// master drives operands and opcode; slave returns the registered result and flags.
interface alu64_registered_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_Op;
    logic [WIDTH-1:0] R;
    logic             zero;
    logic             Overflow;
    logic             CarryOut;
    logic             out_valid;

    modport master (
        output in_valid, A, B, ALU_Op,
        input  R, zero, Overflow, CarryOut, out_valid
    );

    modport slave (
        input  in_valid, A, B, ALU_Op,
        output R, zero, Overflow, CarryOut, out_valid
    );
endinterface

// File: rtl/alu64_registered.sv
// 64-bit ALU built as a ripple of 1-bit slices (AND/OR/ADD/SLT on optionally inverted
// operands), with result, zero, overflow and carry-out captured one clock after in_valid.
module alu64_slice (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       ainv_i,
    input  logic       binv_i,
    input  logic       cin_i,
    input  logic       less_i,
    input  logic [1:0] op_i,
    output logic       res_o,
    output logic       cout_o
);
    logic a, b, sum;

    always_comb begin
        a      = a_i ^ ainv_i;
        b      = b_i ^ binv_i;
        sum    = a ^ b ^ cin_i;
        cout_o = (a & b) | (cin_i & (a ^ b));
        unique case (op_i)
            2'b00:   res_o = a & b;
            2'b01:   res_o = a | b;
            2'b10:   res_o = sum;
            default: res_o = less_i;
        endcase
    end
endmodule

module alu64_registered #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    alu64_registered_if.slave  alu_if
);
    logic             ainv, binv;
    logic [1:0]       op;
    logic [WIDTH-1:0] res_w;
    logic             cout_msb, cin_msb, ovf, set;

    assign ainv = alu_if.ALU_Op[3];
    assign binv = alu_if.ALU_Op[2];
    assign op   = alu_if.ALU_Op[1:0];

    // Each slice keeps its own carry wire so the chain is not a self-referencing vector.
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        logic cin, cout, res, less;
        if (i == 0) begin : g_lsb
            assign cin  = binv;
            assign less = set;
        end else begin : g_upper
            assign cin  = g_slice[i-1].cout;
            assign less = 1'b0;
        end
        alu64_slice u_slice (
            .a_i    (alu_if.A[i]),
            .b_i    (alu_if.B[i]),
            .ainv_i (ainv),
            .binv_i (binv),
            .cin_i  (cin),
            .less_i (less),
            .op_i   (op),
            .res_o  (res),
            .cout_o (cout)
        );
        assign res_w[i] = res;
    end

    assign cin_msb  = g_slice[WIDTH-1].cin;
    assign cout_msb = g_slice[WIDTH-1].cout;
    assign ovf      = cin_msb ^ cout_msb;
    // sum[63] ^ ovf reduces to a ^ b ^ cout at the MSB, avoiding a separate sum tap.
    assign set      = (alu_if.A[WIDTH-1] ^ ainv) ^ (alu_if.B[WIDTH-1] ^ binv) ^ cout_msb;

    logic [WIDTH-1:0] r_q, r_d;
    logic             zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d, vld_q, vld_d;

    always_comb begin
        r_d    = r_q;
        zero_d = zero_q;
        ovf_d  = ovf_q;
        cout_d = cout_q;
        vld_d  = alu_if.in_valid;
        if (alu_if.in_valid) begin
            r_d    = res_w;
            zero_d = (res_w == '0);
            ovf_d  = op[1] & ovf;
            cout_d = op[1] & cout_msb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
        end
    end

    assign alu_if.R         = r_q;
    assign alu_if.zero      = zero_q;
    assign alu_if.Overflow  = ovf_q;
    assign alu_if.CarryOut  = cout_q;
    assign alu_if.out_valid = vld_q;
endmodule

// File: tb/tb_alu64_registered.sv
// Directed test-plan checks plus randomized back-to-back traffic against a
// 65-bit arithmetic reference model of the registered ALU.
module tb_alu64_registered;
    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    alu64_registered_if #(.WIDTH(64)) bus ();

    alu64_registered #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .alu_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain 65-bit addition of the conditioned operands.
    task automatic model(input logic [63:0] a_in, input logic [63:0] b_in, input logic [3:0] opc,
                         output logic [63:0] r, output logic z, output logic o, output logic c);
        logic [63:0] a, b;
        logic [64:0] full;
        logic        v;
        a    = opc[3] ? ~a_in : a_in;
        b    = opc[2] ? ~b_in : b_in;
        full = {1'b0, a} + {1'b0, b} + {64'd0, opc[2]};
        v    = (a[63] == b[63]) && (full[63] != a[63]);
        case (opc[1:0])
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = full[63:0];
            default: r = {63'd0, full[63] ^ v};
        endcase
        z = (r == 64'd0);
        o = opc[1] ? v : 1'b0;
        c = opc[1] ? full[64] : 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [63:0] r, input logic z,
                              input logic o, input logic c, input logic v);
        chk({tag, ".R"},         bus.R,                 r);
        chk({tag, ".zero"},      {63'd0, bus.zero},     {63'd0, z});
        chk({tag, ".Overflow"},  {63'd0, bus.Overflow}, {63'd0, o});
        chk({tag, ".CarryOut"},  {63'd0, bus.CarryOut}, {63'd0, c});
        chk({tag, ".out_valid"}, {63'd0, bus.out_valid}, {63'd0, v});
    endtask

    task automatic op_chk(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [3:0] opc, input logic [63:0] r, input logic z,
                          input logic o, input logic c);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.ALU_Op   = opc;
        @(posedge clk);
        #1;
        check_outs(tag, r, z, o, c, 1'b1);
    endtask

    logic [63:0] exp_r;
    logic        exp_z, exp_o, exp_c, exp_v;
    logic [3:0]  ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1101};
    logic [63:0] corners [6] = '{64'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
                                 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000};

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.A        = 64'd0;
        bus.B        = 64'd0;
        bus.ALU_Op   = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        op_chk("and",  64'd20, 64'd120, 4'b0000, 64'd16, 1'b0, 1'b0, 1'b0);
        op_chk("or",   64'd20, 64'd120, 4'b0001, 64'd124, 1'b0, 1'b0, 1'b0);
        op_chk("nor",  64'd20, 64'd120, 4'b1100, -64'sd125, 1'b0, 1'b0, 1'b0);
        op_chk("nand", 64'd20, 64'd120, 4'b1101, -64'sd17, 1'b0, 1'b0, 1'b0);
        op_chk("add",  64'd20, 64'd120, 4'b0010, 64'd140, 1'b0, 1'b0, 1'b0);
        op_chk("subn", 64'd20, 64'd120, 4'b0110, -64'sd100, 1'b0, 1'b0, 1'b0);
        op_chk("subp", 64'd120, 64'd20, 4'b0110, 64'd100, 1'b0, 1'b0, 1'b1);
        op_chk("sub0", 64'd20, 64'd20, 4'b0110, 64'd0, 1'b1, 1'b0, 1'b1);
        op_chk("slt1", 64'd20, 64'd120, 4'b0111, 64'd1, 1'b0, 1'b0, 1'b0);
        op_chk("slt0", 64'd120, 64'd20, 4'b0111, 64'd0, 1'b1, 1'b0, 1'b1);
        op_chk("sltovf", 64'h8000_0000_0000_0000, 64'd1, 4'b0111, 64'd1, 1'b0, 1'b1, 1'b1);
        op_chk("addovf", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'b0010,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        op_chk("nota_add", 64'd5, 64'd10, 4'b1010, 64'd4, 1'b0, 1'b0, 1'b1);

        // Idle cycle: outputs hold, out_valid drops.
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.A        = 64'hDEAD_BEEF;
        bus.ALU_Op   = 4'b0001;
        @(posedge clk);
        #1;
        check_outs("hold", 64'd4, 1'b0, 1'b0, 1'b1, 1'b0);

        exp_r = 64'd4; exp_z = 1'b0; exp_o = 1'b0; exp_c = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [63:0] a, b, r;
            logic [3:0]  opc;
            logic        z, o, c, vin;
            @(negedge clk);
            vin = ($urandom_range(3, 0) != 0);
            a   = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(5, 0)] : {$urandom, $urandom};
            b   = ($urandom_range(3, 0) == 0) ? corners[$urandom_range(5, 0)] : {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) b = a;
            opc = ($urandom_range(4, 0) == 0) ? 4'($urandom) : ops[$urandom_range(6, 0)];
            bus.in_valid = vin;
            bus.A        = a;
            bus.B        = b;
            bus.ALU_Op   = opc;
            model(a, b, opc, r, z, o, c);
            if (vin) begin
                exp_r = r; exp_z = z; exp_o = o; exp_c = c;
            end
            exp_v = vin;
            @(posedge clk);
            #1;
            check_outs($sformatf("rnd%0d op%b", i, opc), exp_r, exp_z, exp_o, exp_c, exp_v);
        end

        // Asynchronous reset between edges.
        op_chk("prerst", 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 4'b0010,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("asyncrst", 64'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.A      = 64'd7;
        bus.B      = 64'd9;
        bus.ALU_Op = 4'b0010;
        rst_n      = 1'b1;
        @(posedge clk);
        #1;
        check_outs("postrst", 64'd16, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
